alu_op_sequencer: RTL and testbench

- Sequential front-end that owns the 8-bit ALU's control interface.
- Accepts operation commands over a valid/ready handshake and drives ALU operands, opcode and active-low chip select.
- Holds operands stable for a programmable settle window, captures the ALU result, and returns it over a valid/ready response channel.
- Keeps an accumulator so chained operations can reuse the previous result as operand A.

---
 rtl/alu_op_sequencer.sv | 98 +++++++++
 tb/tb_alu_op_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Command front-end for the 8-bit ALU: issues operands under chip select, waits a
// programmable settle window, captures the result and returns it on a response channel.
module alu_op_sequencer #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    input  logic             acc_clr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] acc,
    output logic             busy,
    output logic             alu_cs_n,
    output logic [1:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_data1,
    output logic [WIDTH-1:0] alu_data2,
    input  logic [WIDTH-1:0] alu_result
);

    // state | meaning
    // IDLE  | ready for a command, ALU deselected
    // ISSUE | operands driven, alu_cs_n low, settle counter running
    // RESP  | result held on rsp_data until the consumer takes it
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] settle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= 4'd0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_zero   <= 1'b0;
            acc        <= '0;
            busy       <= 1'b0;
            alu_cs_n   <= 1'b1;
            alu_opcode <= 2'b00;
            alu_data1  <= '0;
            alu_data2  <= '0;
        end else begin
            // Capture below is written later so it overrides a coincident clear.
            if (acc_clr)
                acc <= '0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        alu_opcode <= cmd_opcode;
                        alu_data1  <= cmd_use_acc ? acc : cmd_a;
                        alu_data2  <= cmd_b;
                        alu_cs_n   <= 1'b0;
                        settle_cnt <= 4'(SETTLE_CYCLES);
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else begin
                        rsp_data  <= alu_result;
                        acc       <= alu_result;
                        rsp_zero  <= (alu_result == '0);
                        alu_cs_n  <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios plus randomized
// commands checked against an accumulator/arithmetic reference model.
module tb_alu_op_sequencer;
    localparam int SETTLE = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0, cmd_use_acc = 1'b0, acc_clr = 1'b0, rsp_ready = 1'b0;
    logic [1:0] cmd_opcode = 2'b00;
    logic [7:0] cmd_a = 8'h00, cmd_b = 8'h00;

    logic       cmd_ready, rsp_valid, rsp_zero, busy, alu_cs_n;
    logic [1:0] alu_opcode;
    logic [7:0] rsp_data, acc, alu_data1, alu_data2, alu_result;

    logic       s3_cmd_ready, s3_rsp_valid, s3_rsp_zero, s3_busy, s3_alu_cs_n;
    logic [1:0] s3_alu_opcode;
    logic [7:0] s3_rsp_data, s3_acc, s3_alu_data1, s3_alu_data2, s3_alu_result;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_acc = 8'h00;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
        case (op)
            2'b00:   return x + y;
            2'b01:   return x - y;
            2'b10:   return x & y;
            default: return x | y;
        endcase
    endfunction

    assign alu_result    = alu_ref(alu_opcode, alu_data1, alu_data2);
    assign s3_alu_result = alu_ref(s3_alu_opcode, s3_alu_data1, s3_alu_data2);

    alu_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .acc_clr(acc_clr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .acc(acc), .busy(busy), .alu_cs_n(alu_cs_n),
        .alu_opcode(alu_opcode), .alu_data1(alu_data1), .alu_data2(alu_data2),
        .alu_result(alu_result)
    );

    alu_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(s3_cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .acc_clr(acc_clr), .rsp_valid(s3_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(s3_rsp_data),
        .rsp_zero(s3_rsp_zero), .acc(s3_acc), .busy(s3_busy), .alu_cs_n(s3_alu_cs_n),
        .alu_opcode(s3_alu_opcode), .alu_data1(s3_alu_data1), .alu_data2(s3_alu_data2),
        .alu_result(s3_alu_result)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full command/response transaction against the SETTLE=1 instance.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic use_acc, input int hold, input bit clr_e0, input bit clr_cap,
                           input bit chain, input logic [1:0] nop, input logic [7:0] na, input logic [7:0] nb);
        logic [7:0] exp_a, exp_r;
        int         cs_low, lat;
        bit         done;
        exp_a = use_acc ? model_acc : a;
        exp_r = alu_ref(op, exp_a, b);
        cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_use_acc = use_acc; cmd_valid = 1'b1;
        acc_clr = clr_e0;
        checks++;
        if (cmd_ready !== 1'b1 || alu_cs_n !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: cmd_ready=%b cs_n=%b required 1 1", cmd_ready, alu_cs_n);
        end
        tick();
        cmd_valid = 1'b0; acc_clr = 1'b0;
        if (clr_e0) model_acc = 8'h00;
        checks++;
        if (alu_cs_n !== 1'b0 || alu_opcode !== op || alu_data1 !== exp_a || alu_data2 !== b) begin
            errors++;
            $display("FAIL issue_operands: cs_n=%b op=%h d1=%h d2=%h required 0 %h %h %h",
                     alu_cs_n, alu_opcode, alu_data1, alu_data2, op, exp_a, b);
        end
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1 || acc !== model_acc) begin
            errors++;
            $display("FAIL issue_flags: ready=%b busy=%b acc=%h required 0 1 %h", cmd_ready, busy, acc, model_acc);
        end
        cs_low = 1; lat = 0; done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (clr_cap && cs_low == SETTLE + 1) acc_clr = 1'b1;
            tick();
            acc_clr = 1'b0;
            lat++;
            if (alu_cs_n === 1'b1) begin
                done = 1'b1;
                break;
            end
            cs_low++;
            checks++;
            if (alu_opcode !== op || alu_data1 !== exp_a || alu_data2 !== b || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL operand_hold: op=%h d1=%h d2=%h rsp_valid=%b required %h %h %h 0",
                         alu_opcode, alu_data1, alu_data2, rsp_valid, op, exp_a, b);
            end
        end
        checks++;
        if (!done || cs_low != SETTLE + 1 || lat != SETTLE + 1) begin
            errors++;
            $display("FAIL cs_window: done=%0d cs_low=%0d latency=%0d required 1 %0d %0d",
                     done, cs_low, lat, SETTLE + 1, SETTLE + 1);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_r || rsp_zero !== (exp_r == 8'h00) || acc !== exp_r) begin
            errors++;
            $display("FAIL result: valid=%b data=%h zero=%b acc=%h required 1 %h %b %h",
                     rsp_valid, rsp_data, rsp_zero, acc, exp_r, (exp_r == 8'h00), exp_r);
        end
        model_acc = exp_r;
        if (chain) begin
            cmd_opcode = nop; cmd_a = na; cmd_b = nb; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_r || cmd_ready !== 1'b0 || alu_cs_n !== 1'b1 ||
                alu_data1 !== exp_a) begin
                errors++;
                $display("FAIL backpressure: valid=%b data=%h ready=%b cs_n=%b d1=%h required 1 %h 0 1 %h",
                         rsp_valid, rsp_data, cmd_ready, alu_cs_n, alu_data1, exp_r, exp_a);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || alu_cs_n !== 1'b1) begin
            errors++;
            $display("FAIL handshake: valid=%b ready=%b busy=%b cs_n=%b required 0 1 0 1",
                     rsp_valid, cmd_ready, busy, alu_cs_n);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 || alu_cs_n !== 1'b1 || rsp_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: ready=%b valid=%b busy=%b cs_n=%b zero=%b required 1 0 0 1 0",
                     cmd_ready, rsp_valid, busy, alu_cs_n, rsp_zero);
        end
        checks++;
        if (rsp_data !== 8'h00 || acc !== 8'h00 || alu_opcode !== 2'b00 || alu_data1 !== 8'h00 || alu_data2 !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: data=%h acc=%h op=%h d1=%h d2=%h required all zero",
                     rsp_data, acc, alu_opcode, alu_data1, alu_data2);
        end
        tick();
        tick();
        rst = 1'b0;
        model_acc = 8'h00;
        tick();
    endtask

    task automatic test_reset_mid();
        cmd_opcode = 2'b00; cmd_a = 8'h21; cmd_b = 8'h12; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++;
        if (s3_alu_cs_n !== 1'b0 || s3_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_issue: s3 cs_n=%b busy=%b required 0 1", s3_alu_cs_n, s3_busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (s3_alu_cs_n !== 1'b1 || s3_rsp_valid !== 1'b0 || s3_acc !== 8'h00 || s3_busy !== 1'b0 || alu_cs_n !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: s3 cs_n=%b valid=%b acc=%h busy=%b dut cs_n=%b required 1 0 00 0 1",
                     s3_alu_cs_n, s3_rsp_valid, s3_acc, s3_busy, alu_cs_n);
        end
        tick();
        rst = 1'b0;
        model_acc = 8'h00;
        checks++;
        if (s3_cmd_ready !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: s3=%b dut=%b required 1 1", s3_cmd_ready, cmd_ready);
        end
        begin
            bit bad = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (s3_rsp_valid !== 1'b0 || s3_alu_cs_n !== 1'b1 || rsp_valid !== 1'b0) bad = 1'b1;
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL dropped_cmd: response or cs activity after reset, s3 valid=%b cs_n=%b required 0 1",
                         s3_rsp_valid, s3_alu_cs_n);
            end
        end
    endtask

    task automatic test_add();
        run_cmd(2'b00, 8'h05, 8'h03, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        checks++;
        if (acc !== 8'h08 || rsp_data !== 8'h08) begin
            errors++;
            $display("FAIL add_value: acc=%h data=%h required 08 08", acc, rsp_data);
        end
    endtask

    task automatic test_wrap_zero();
        run_cmd(2'b01, 8'h03, 8'h05, 1'b0, 1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        checks++;
        if (rsp_data !== 8'hFE || rsp_zero !== 1'b0) begin
            errors++;
            $display("FAIL sub_wrap: data=%h zero=%b required fe 0", rsp_data, rsp_zero);
        end
        run_cmd(2'b01, 8'h10, 8'h10, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        checks++;
        if (rsp_data !== 8'h00 || rsp_zero !== 1'b1) begin
            errors++;
            $display("FAIL sub_zero: data=%h zero=%b required 00 1", rsp_data, rsp_zero);
        end
    endtask

    task automatic test_acc_chain();
        run_cmd(2'b00, 8'h80, 8'h80, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        run_cmd(2'b11, 8'hAA, 8'h0F, 1'b1, 0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        run_cmd(2'b10, 8'h55, 8'h03, 1'b1, 2, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        checks++;
        if (acc !== 8'h03) begin
            errors++;
            $display("FAIL acc_chain: acc=%h required 03", acc);
        end
    endtask

    task automatic test_back_to_back();
        run_cmd(2'b00, 8'h11, 8'h22, 1'b0, 5, 1'b0, 1'b0, 1'b1, 2'b11, 8'h30, 8'h0C);
        run_cmd(2'b11, 8'h30, 8'h0C, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        checks++;
        if (acc !== 8'h3C) begin
            errors++;
            $display("FAIL back_to_back: acc=%h required 3c", acc);
        end
    endtask

    task automatic test_acc_clr();
        run_cmd(2'b00, 8'h40, 8'h02, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        model_acc = 8'h00;
        checks++;
        if (acc !== 8'h00) begin
            errors++;
            $display("FAIL clr_idle: acc=%h required 00", acc);
        end
        run_cmd(2'b00, 8'h01, 8'h01, 1'b0, 0, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
        checks++;
        if (acc !== 8'h02) begin
            errors++;
            $display("FAIL clr_capture: acc=%h required 02", acc);
        end
        run_cmd(2'b11, 8'hFF, 8'h10, 1'b1, 0, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        checks++;
        if (acc !== 8'h12) begin
            errors++;
            $display("FAIL clr_e0: acc=%h required 12", acc);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                acc_clr = 1'b1;
                tick();
                acc_clr = 1'b0;
                model_acc = 8'h00;
            end
            run_cmd(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                    1'b0, 2'b00, 8'h00, 8'h00);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_add();
        test_wrap_zero();
        test_acc_chain();
        test_back_to_back();
        test_acc_clr();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
